// File: rtl/ctc_kscan.sv
// ctc_kscan: word-time keyboard scanner with debounce and a valid/ack handoff of the key code.
// Optional auto-repeat of a held key is enabled by defining CTC_KSCAN_REPEAT_EN.
module ctc_kscan #(
    parameter int unsigned WORD_LEN   = 56,
    parameter int unsigned N_ROWS     = 8,
    parameter int unsigned N_COLS     = 5,
    parameter int unsigned CODE_W     = 6,
    parameter int unsigned DEBOUNCE   = 2,
    parameter int unsigned REPEAT_DLY = 16
) (
    input  logic              cph2,
    input  logic              nrst,
    input  logic [N_COLS-1:0] kc,
    input  logic              key_ack,
    input  logic              stat_clr,
    output logic [N_ROWS-1:0] kr,
    output logic              word_end,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              kdown_flag
);

    localparam int unsigned N_SLOTS = N_ROWS * N_COLS;
    localparam int unsigned CNT_W   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int unsigned ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned COL_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);
`ifdef CTC_KSCAN_REPEAT_EN
    localparam int unsigned RPT_W   = $clog2(REPEAT_DLY + 1);
`endif

    // Reject configurations the scan/debounce scheme cannot support.
    if (DEBOUNCE < 1 || REPEAT_DLY < 1 || N_SLOTS > WORD_LEN ||
        (N_ROWS & (N_ROWS - 1)) != 0 || (2 ** CODE_W) < N_SLOTS) begin : g_bad_param
        $error("ctc_kscan: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB,
        S_VALID,
        S_REL
    } state_t;

    logic [CNT_W-1:0]  cnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [CODE_W-1:0] code_now;
    logic              slot_valid;
    logic              slot_hit;
    logic              cand_hit;
    logic              hit_any;

    state_t            state, state_n;
    logic [CODE_W-1:0] cand, cand_n;
    logic [DEB_W-1:0]  deb_cnt, deb_n;
    logic              hit, hit_n;
    logic              part, part_n;
    logic              kv_n;
    logic [CODE_W-1:0] code_n;
    logic              kd_n;
`ifdef CTC_KSCAN_REPEAT_EN
    logic [RPT_W-1:0]  rpt_cnt, rpt_n;
`endif

    // Free-running word-time counter.
    always_ff @(posedge cph2 or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (word_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign word_end   = (cnt == CNT_W'(WORD_LEN - 1));
    assign slot_valid = (32'(cnt) < N_SLOTS);
    assign row        = ROW_W'(32'(cnt) % N_ROWS);
    assign col        = COL_W'(32'(cnt) / N_ROWS);
    assign code_now   = CODE_W'(cnt);
    assign slot_hit   = slot_valid & kc[col];
    assign cand_hit   = slot_hit & (code_now == cand);
    assign hit_any    = hit | cand_hit;

    always_comb begin
        kr = '0;
        if (slot_valid) kr[row] = 1'b1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        deb_n   = deb_cnt;
        hit_n   = hit;
        part_n  = part;
        kv_n    = key_valid;
        code_n  = key_code;
        kd_n    = kdown_flag;
`ifdef CTC_KSCAN_REPEAT_EN
        rpt_n   = rpt_cnt;
`endif
        if (stat_clr) kd_n = 1'b0;

        case (state)
            S_IDLE: begin
                // Slots are scanned in code order, so the first hit is the lowest code.
                if (slot_hit) begin
                    state_n = S_DEB;
                    cand_n  = code_now;
                    deb_n   = DEB_W'(1);
                    hit_n   = !word_end;
                end
            end
            S_DEB: begin
                if (word_end) begin
                    hit_n = 1'b0;
                    if (!hit_any) begin
                        state_n = S_IDLE;
                    end else if (deb_cnt == DEB_W'(DEBOUNCE)) begin
                        state_n = S_VALID;
                        kv_n    = 1'b1;
                        code_n  = cand;
                        kd_n    = 1'b1;
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end else if (cand_hit) begin
                    hit_n = 1'b1;
                end
            end
            S_VALID: begin
                if (key_ack) begin
                    state_n = S_REL;
                    kv_n    = 1'b0;
                    hit_n   = 1'b0;
                    // A partially elapsed word does not count as a released word.
                    part_n  = !word_end;
`ifdef CTC_KSCAN_REPEAT_EN
                    rpt_n   = '0;
`endif
                end
            end
            S_REL: begin
                if (word_end) begin
                    hit_n  = 1'b0;
                    part_n = 1'b0;
                    if (!part) begin
                        if (!hit_any) begin
                            state_n = S_IDLE;
                        end
`ifdef CTC_KSCAN_REPEAT_EN
                        else if (rpt_cnt == RPT_W'(REPEAT_DLY - 1)) begin
                            state_n = S_VALID;
                            kv_n    = 1'b1;
                            kd_n    = 1'b1;
                        end else begin
                            rpt_n = rpt_cnt + RPT_W'(1);
                        end
`endif
                    end
                end else if (cand_hit) begin
                    hit_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge cph2 or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            cand       <= '0;
            deb_cnt    <= '0;
            hit        <= 1'b0;
            part       <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            kdown_flag <= 1'b0;
`ifdef CTC_KSCAN_REPEAT_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            deb_cnt    <= deb_n;
            hit        <= hit_n;
            part       <= part_n;
            key_valid  <= kv_n;
            key_code   <= code_n;
            kdown_flag <= kd_n;
`ifdef CTC_KSCAN_REPEAT_EN
            rpt_cnt    <= rpt_n;
`endif
        end
    end

endmodule

// File: tb/tb_ctc_kscan.sv
// tb_ctc_kscan: directed bench for ctc_kscan (default build) with a key-matrix model and a
// scoreboard of expected key presentations checked by an independent monitor.
module tb_ctc_kscan;

    logic        cph2 = 1'b0;
    logic        nrst;
    logic [4:0]  kc;
    logic        key_ack;
    logic        stat_clr;
    logic [7:0]  kr;
    logic        word_end;
    logic        key_valid;
    logic [5:0]  key_code;
    logic        kdown_flag;

    logic [39:0] pressed;
    int          tcnt = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_kv = 1'b0;

    typedef struct {
        int   cyc;
        int   code;
        logic kd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t left_e;

    ctc_kscan dut (
        .cph2       (cph2),
        .nrst       (nrst),
        .kc         (kc),
        .key_ack    (key_ack),
        .stat_clr   (stat_clr),
        .kr         (kr),
        .word_end   (word_end),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .kdown_flag (kdown_flag)
    );

    always #5 cph2 = ~cph2;

    // Key matrix: a pressed key at code c*8+r connects row r to column c.
    always_comb begin
        kc = '0;
        for (int c = 0; c < 5; c++) kc[c] = |(pressed[c*8 +: 8] & kr);
    end

    // Reference word-time counter and global cycle count.
    always @(posedge cph2 or negedge nrst) begin
        if (!nrst) tcnt <= 0;
        else       tcnt <= (tcnt == 55) ? 0 : tcnt + 1;
    end

    always @(posedge cph2) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] exp_kr(input int c);
        logic [7:0] r;
        r = '0;
        if (c < 40) r[c % 8] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge cph2);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic to_word_start();
        for (int i = 0; i < 56 && tcnt != 0; i++) tick();
    endtask

    task automatic push(input int code, input int at_cyc);
        exp_t e;
        e.cyc  = at_cyc;
        e.code = code;
        e.kd   = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_kr"}, 32'(kr), 32'h01);
        chk({tag, "_word_end"}, 32'(word_end), 32'd0);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_key_code"}, 32'(key_code), 32'd0);
        chk({tag, "_kdown"}, 32'(kdown_flag), 32'd0);
    endtask

    // Monitor: every rising key_valid must match the oldest expected presentation.
    always @(negedge cph2) begin
        if (key_valid === 1'b1 && prev_kv !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: key_valid rose with code %0d, none expected (cycle %0d)",
                         key_code, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("valid_key_code", 32'(key_code), 32'(mon_e.code));
                chk("valid_kdown", 32'(kdown_flag), 32'(mon_e.kd));
            end
        end
        prev_kv = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst     = 1'b0;
        key_ack  = 1'b0;
        stat_clr = 1'b0;
        pressed  = '0;
        #12;
        chk_reset_outputs("reset");
        #1 nrst = 1'b1;

        // Scan sequence over one word.
        for (int i = 0; i < 56; i++) begin
            chk($sformatf("scan_kr[%0d]", tcnt), 32'(kr), 32'(exp_kr(tcnt)));
            chk($sformatf("scan_word_end[%0d]", tcnt), 32'(word_end), 32'(tcnt == 55));
            tick();
        end

        // Code 19 held two words, then released and acknowledged.
        to_word_start();
        pressed[19] = 1'b1;
        push(19, cyc + 112);
        ticks(112);
        pressed[19] = 1'b0;
        ticks(10);
        chk("hold_valid", 32'(key_valid), 32'd1);
        chk("hold_code", 32'(key_code), 32'd19);
        pulse_ack();
        chk("ack_drops_valid", 32'(key_valid), 32'd0);
        chk("kdown_after_ack", 32'(kdown_flag), 32'd1);
        ticks(168);

        // Code 19 held for one word only.
        to_word_start();
        pressed[19] = 1'b1;
        ticks(56);
        pressed[19] = 1'b0;
        chk("short_press_pending", 32'(key_valid), 32'd0);
        ticks(112);
        chk("short_press_no_valid", 32'(key_valid), 32'd0);

        // Codes 5 and 19 together: lowest wins; ack while both held.
        to_word_start();
        pressed[5]  = 1'b1;
        pressed[19] = 1'b1;
        push(5, cyc + 112);
        ticks(112);
        pulse_ack();
        chk("multi_ack_drops", 32'(key_valid), 32'd0);
        ticks(168);
        chk("held_single_valid", 32'(key_valid), 32'd0);

        // One released word, clear the flag, then re-press 5 with stat_clr on the set edge.
        to_word_start();
        pressed = '0;
        ticks(10);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_clears", 32'(kdown_flag), 32'd0);
        to_word_start();
        pressed[5] = 1'b1;
        push(5, cyc + 112);
        ticks(111);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        ticks(3);
        chk("set_beats_clr", 32'(kdown_flag), 32'd1);
        chk("repress_code", 32'(key_code), 32'd5);
        pressed = '0;
        pulse_ack();
        ticks(168);

        // Reset in the middle of debouncing.
        to_word_start();
        pressed[19] = 1'b1;
        ticks(30);
        nrst = 1'b0;
        #1;
        chk_reset_outputs("rst_deb");
        pressed = '0;
        #2 nrst = 1'b1;
        ticks(112);
        chk("rst_deb_no_valid", 32'(key_valid), 32'd0);

        // Reset while a code is presented.
        to_word_start();
        pressed[19] = 1'b1;
        push(19, cyc + 112);
        ticks(117);
        chk("pre_rst_valid", 32'(key_valid), 32'd1);
        nrst = 1'b0;
        #1;
        chk_reset_outputs("rst_valid");
        pressed = '0;
        #2 nrst = 1'b1;
        ticks(112);
        chk("rst_valid_no_valid", 32'(key_valid), 32'd0);

        while (exp_q.size() > 0) begin
            left_e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_valid: code %0d expected at cycle %0d was never presented",
                     left_e.code, left_e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
